// File: rtl/axi4lite_master_bridge.sv
// ---------------------------------------------------------------------------
// axi4lite_master_bridge
//
// Single-outstanding AXI4-Lite master. A host sequencer (e.g. a UART debug
// bridge) issues one command at a time on a valid/ready command port; the
// bridge runs the matching AXI4-Lite write (AW+W then B) or read (AR then R)
// and returns the slave response on a valid/ready response port. Each AXI
// wait state is guarded by an optional timeout that aborts the transaction
// and reports rsp_resp = 2'b11 with rsp_timeout = 1.
//
// Ports
//   CLK, RST              clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_write             1 = write, 0 = read
//   cmd_addr              target byte address
//   cmd_wdata/cmd_wstrb   write data and byte strobes (ignored on reads)
//   rsp_valid/rsp_ready   response handshake; rsp_* held until consumed
//   rsp_rdata             read data (0 for writes and timeouts)
//   rsp_resp              BRESP/RRESP passed through, 2'b11 on timeout
//   rsp_timeout           transaction aborted by timeout
//   M_AXI_*               AXI4-Lite master channels (AW, W, B, AR, R)
//
// Parameters
//   ADDR_WIDTH, DATA_WIDTH  AXI address/data widths, strobe = DATA_WIDTH/8
//   TIMEOUT_CYCLES          cycles allowed in one wait state, 0 = no timeout
// ---------------------------------------------------------------------------
module axi4lite_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    CLK,
    input  logic                    RST,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,

    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,

    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,

    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    input  logic [1:0]              M_AXI_BRESP,

    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,

    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP
);

    localparam bit TMO_EN    = (TIMEOUT_CYCLES > 0);
    localparam int CNT_WIDTH = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    // Abort fires on the last permitted cycle, so a wait state lasts at most
    // TIMEOUT_CYCLES cycles.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        TMO_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        DONE
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] tmo_cnt;

    logic wr_req_done;
    logic state_exit;
    logic in_wait;
    logic tmo_expire;

    // Protection attributes are fixed: unprivileged, secure, data access.
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;

    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        // A channel counts as finished once its VALID has already dropped or
        // its handshake completes this cycle; AW and W finish in any order.
        wr_req_done = (!M_AXI_AWVALID || M_AXI_AWREADY) &&
                      (!M_AXI_WVALID  || M_AXI_WREADY);
        state_exit  = 1'b0;
        case (state)
            WR_REQ:  state_exit = wr_req_done;
            WR_RESP: state_exit = M_AXI_BVALID;
            RD_REQ:  state_exit = M_AXI_ARREADY;
            RD_DATA: state_exit = M_AXI_RVALID;
            default: state_exit = 1'b0;
        endcase
        in_wait    = (state inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA});
        // A handshake landing on the final cycle wins over the abort.
        tmo_expire = TMO_EN && in_wait && !state_exit && (tmo_cnt == CNT_LAST);
    end

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            rsp_timeout   <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            // Counts time spent in the current wait state; cleared on every
            // state change below (later assignments override this one).
            if (in_wait) begin
                tmo_cnt <= (tmo_cnt == CNT_MAX) ? tmo_cnt : tmo_cnt + 1'b1;
            end

            if (tmo_expire) begin
                M_AXI_AWVALID <= 1'b0;
                M_AXI_WVALID  <= 1'b0;
                M_AXI_BREADY  <= 1'b0;
                M_AXI_ARVALID <= 1'b0;
                M_AXI_RREADY  <= 1'b0;
                rsp_rdata     <= '0;
                rsp_resp      <= 2'b11;
                rsp_timeout   <= 1'b1;
                rsp_valid     <= 1'b1;
                tmo_cnt       <= '0;
                state         <= DONE;
            end else begin
                case (state)
                    IDLE: begin
                        tmo_cnt <= '0;
                        if (cmd_valid && cmd_ready) begin
                            cmd_ready <= 1'b0;
                            if (cmd_write) begin
                                M_AXI_AWADDR  <= cmd_addr;
                                M_AXI_WDATA   <= cmd_wdata;
                                M_AXI_WSTRB   <= cmd_wstrb;
                                M_AXI_AWVALID <= 1'b1;
                                M_AXI_WVALID  <= 1'b1;
                                state         <= WR_REQ;
                            end else begin
                                M_AXI_ARADDR  <= cmd_addr;
                                M_AXI_ARVALID <= 1'b1;
                                state         <= RD_REQ;
                            end
                        end
                    end

                    WR_REQ: begin
                        if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                        if (M_AXI_WVALID  && M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                        if (wr_req_done) begin
                            M_AXI_BREADY <= 1'b1;
                            tmo_cnt      <= '0;
                            state        <= WR_RESP;
                        end
                    end

                    WR_RESP: begin
                        if (M_AXI_BVALID) begin
                            M_AXI_BREADY <= 1'b0;
                            rsp_rdata    <= '0;
                            rsp_resp     <= M_AXI_BRESP;
                            rsp_timeout  <= 1'b0;
                            rsp_valid    <= 1'b1;
                            tmo_cnt      <= '0;
                            state        <= DONE;
                        end
                    end

                    RD_REQ: begin
                        if (M_AXI_ARREADY) begin
                            M_AXI_ARVALID <= 1'b0;
                            M_AXI_RREADY  <= 1'b1;
                            tmo_cnt       <= '0;
                            state         <= RD_DATA;
                        end
                    end

                    RD_DATA: begin
                        if (M_AXI_RVALID) begin
                            M_AXI_RREADY <= 1'b0;
                            rsp_rdata    <= M_AXI_RDATA;
                            rsp_resp     <= M_AXI_RRESP;
                            rsp_timeout  <= 1'b0;
                            rsp_valid    <= 1'b1;
                            tmo_cnt      <= '0;
                            state        <= DONE;
                        end
                    end

                    DONE: begin
                        // cmd_ready returns only after the response is taken,
                        // so a new command is never accepted in this state.
                        if (rsp_ready) begin
                            rsp_valid <= 1'b0;
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi4lite_master_bridge
//
// Drives host commands into the bridge against a behavioural register-file
// slave (32 word registers at 0x00..0x7C; partial strobes and unmapped
// addresses answer SLVERR). Expected responses are queued when a command is
// accepted and compared when the bridge hands the response back.
// ---------------------------------------------------------------------------
module tb_axi4lite_master_bridge;

    localparam int TMO = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    logic        M_AXI_AWVALID, M_AXI_AWREADY;
    logic [31:0] M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_WVALID, M_AXI_WREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_BVALID, M_AXI_BREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_ARVALID, M_AXI_ARREADY;
    logic [31:0] M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_RVALID, M_AXI_RREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;

    axi4lite_master_bridge #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .rsp_timeout  (rsp_timeout),
        .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_AWADDR (M_AXI_AWADDR),
        .M_AXI_AWPROT (M_AXI_AWPROT),
        .M_AXI_WVALID (M_AXI_WVALID),
        .M_AXI_WREADY (M_AXI_WREADY),
        .M_AXI_WDATA  (M_AXI_WDATA),
        .M_AXI_WSTRB  (M_AXI_WSTRB),
        .M_AXI_BVALID (M_AXI_BVALID),
        .M_AXI_BREADY (M_AXI_BREADY),
        .M_AXI_BRESP  (M_AXI_BRESP),
        .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_ARADDR (M_AXI_ARADDR),
        .M_AXI_ARPROT (M_AXI_ARPROT),
        .M_AXI_RVALID (M_AXI_RVALID),
        .M_AXI_RREADY (M_AXI_RREADY),
        .M_AXI_RDATA  (M_AXI_RDATA),
        .M_AXI_RRESP  (M_AXI_RRESP)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
    } rsp_t;

    rsp_t sb_q[$];

    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge CLK);
            if (!RST && rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_rsp: got resp 0x%0h with no command pending", rsp_resp);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_resp", rsp_resp, e.resp);
                    check("rsp_timeout", rsp_timeout, e.tmo);
                end
            end
        end
    end

    // ---------------- slave model ----------------
    logic [31:0] slv_mem [32];
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    bit          ar_block = 1'b0, b_hold = 1'b0;
    int          b_hs_total = 0;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_strb;

    initial begin
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
        M_AXI_BRESP   = 2'b00; M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
        M_AXI_RDATA   = '0;    M_AXI_RRESP   = 2'b00;
    end

    function automatic bit addr_ok(input logic [31:0] a);
        return (a < 32'h80) && (a[1:0] == 2'b00);
    endfunction

    initial begin : slave
        logic hs_aw, hs_w, hs_b, hs_ar, hs_r, pv_aw, pv_w;
        logic [31:0] pa_aw, pa_wd, pa_ar, s_awaddr, s_wdata;
        logic [3:0]  pa_ws, s_wstrb;
        bit aw_got, w_got;
        int aw_cnt, w_cnt, ar_cnt;
        aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        s_awaddr = '0; s_wdata = '0; s_wstrb = '0;
        for (int i = 0; i < 32; i++) slv_mem[i] = '0;
        forever begin
            @(negedge CLK);
            hs_aw = M_AXI_AWVALID && M_AXI_AWREADY;
            hs_w  = M_AXI_WVALID  && M_AXI_WREADY;
            hs_b  = M_AXI_BVALID  && M_AXI_BREADY;
            hs_ar = M_AXI_ARVALID && M_AXI_ARREADY;
            hs_r  = M_AXI_RVALID  && M_AXI_RREADY;
            pv_aw = M_AXI_AWVALID; pv_w = M_AXI_WVALID;
            pa_aw = M_AXI_AWADDR;  pa_wd = M_AXI_WDATA;
            pa_ws = M_AXI_WSTRB;   pa_ar = M_AXI_ARADDR;
            @(posedge CLK); #1;
            if (RST) begin
                M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
                M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
                aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                continue;
            end
            if (hs_aw) begin
                aw_got = 1; s_awaddr = pa_aw;
                check("awvalid_drop_after_hs", M_AXI_AWVALID, 1'b0);
                check("awaddr", pa_aw, exp_addr);
            end else if (pv_aw) begin
                check("awvalid_held", M_AXI_AWVALID, 1'b1);
                check("awaddr_stable", M_AXI_AWADDR, pa_aw);
            end
            if (hs_w) begin
                w_got = 1; s_wdata = pa_wd; s_wstrb = pa_ws;
                check("wvalid_drop_after_hs", M_AXI_WVALID, 1'b0);
                check("wdata_wstrb", {pa_wd, pa_ws}, {exp_wdata, exp_strb});
            end else if (pv_w) begin
                check("wvalid_held", M_AXI_WVALID, 1'b1);
                check("wdata_stable", {M_AXI_WDATA, M_AXI_WSTRB}, {pa_wd, pa_ws});
            end
            if (hs_b) begin
                M_AXI_BVALID = 1'b0;
                b_hs_total++;
                check("bready_drop_after_hs", M_AXI_BREADY, 1'b0);
            end
            if (hs_r) begin
                M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
            end
            if (hs_ar) begin
                check("arvalid_drop_after_hs", M_AXI_ARVALID, 1'b0);
                check("araddr", pa_ar, exp_addr);
                M_AXI_RVALID = 1'b1;
                M_AXI_RDATA  = addr_ok(pa_ar) ? slv_mem[pa_ar[6:2]] : '0;
                M_AXI_RRESP  = addr_ok(pa_ar) ? 2'b00 : 2'b10;
            end
            if (M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_cnt >= aw_delay); aw_cnt++; end
            else begin M_AXI_AWREADY = 1'b0; aw_cnt = 0; end
            if (M_AXI_WVALID) begin M_AXI_WREADY = (w_cnt >= w_delay); w_cnt++; end
            else begin M_AXI_WREADY = 1'b0; w_cnt = 0; end
            if (M_AXI_ARVALID) begin M_AXI_ARREADY = !ar_block && (ar_cnt >= ar_delay); ar_cnt++; end
            else begin M_AXI_ARREADY = 1'b0; ar_cnt = 0; end
            if (aw_got && w_got && !b_hold && !M_AXI_BVALID) begin
                if (!addr_ok(s_awaddr) || s_wstrb != 4'hF) begin
                    M_AXI_BRESP = 2'b10;
                end else begin
                    slv_mem[s_awaddr[6:2]] = s_wdata;
                    M_AXI_BRESP = 2'b00;
                end
                M_AXI_BVALID = 1'b1;
                aw_got = 0; w_got = 0;
            end
        end
    end

    // ---------------- host driver ----------------
    // Called and returning at posedge+1; t0 is the cycle of the accept edge.
    task automatic send_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input rsp_t exp, output int t0);
        int  n = 0;
        bit  ok = 0;
        exp_addr = addr; exp_wdata = wdata; exp_strb = strb;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
        cmd_valid = 1'b1;
        t0 = cyc;
        while (n < 100) begin
            @(negedge CLK);
            if (cmd_ready) begin ok = 1; break; end
            n++;
        end
        if (ok) begin
            t0 = cyc;
            sb_q.push_back(exp);
        end else begin
            checks++; errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready stayed 0 for %0d cycles", n);
        end
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_rsp_timeout: %0d responses still pending", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_reset(input string name);
        check({name, "_ctrl"},
              {cmd_ready, rsp_valid, rsp_timeout, rsp_resp, M_AXI_AWVALID, M_AXI_WVALID,
               M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWPROT, M_AXI_ARPROT},
              16'h8000);
        check({name, "_rdata"}, rsp_rdata, 32'h0);
        check({name, "_addr"}, {M_AXI_AWADDR, M_AXI_ARADDR}, 64'h0);
        check({name, "_wdata_strb"}, {M_AXI_WDATA, M_AXI_WSTRB}, 36'h0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          awd;
        int          wd;
        int          ard;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [12];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   t0, n, bad, writes;
        rsp_t ex;

        vecs[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0,        2'b00};
        vecs[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 0, 0, 0, 32'hDEADBEEF, 2'b00};
        vecs[2]  = '{1'b1, 32'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 32'h0,        2'b00};
        vecs[3]  = '{1'b1, 32'h08, 32'h12345678, 4'h6, 0, 0, 0, 32'h0,        2'b10};
        vecs[4]  = '{1'b0, 32'h08, 32'h0,        4'h0, 0, 0, 0, 32'hFFFFFFFF, 2'b00};
        vecs[5]  = '{1'b0, 32'h88, 32'h0,        4'h0, 0, 0, 0, 32'h0,        2'b10};
        vecs[6]  = '{1'b1, 32'h88, 32'hCAFEF00D, 4'hF, 0, 0, 0, 32'h0,        2'b10};
        vecs[7]  = '{1'b1, 32'h0C, 32'hA5A55A5A, 4'hF, 3, 0, 0, 32'h0,        2'b00};
        vecs[8]  = '{1'b1, 32'h10, 32'h0F0FF0F0, 4'hF, 0, 3, 0, 32'h0,        2'b00};
        vecs[9]  = '{1'b0, 32'h0C, 32'h0,        4'h0, 0, 0, 2, 32'hA5A55A5A, 2'b00};
        vecs[10] = '{1'b0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 32'h0F0FF0F0, 2'b00};
        vecs[11] = '{1'b1, 32'h14, 32'h13579BDF, 4'hF, 2, 2, 0, 32'h0,        2'b00};

        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b1;
        writes = 0;

        repeat (3) @(posedge CLK);
        #1;
        check_reset("reset");
        RST = 1'b0;
        @(posedge CLK); #1;

        // Table: main function with several slave timing patterns.
        foreach (vecs[i]) begin
            aw_delay = vecs[i].awd; w_delay = vecs[i].wd; ar_delay = vecs[i].ard;
            ex = '{vecs[i].exp_rdata, vecs[i].exp_resp, 1'b0};
            send_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, ex, t0);
            wait_rsp($sformatf("vec%0d", i));
            if (vecs[i].wr) begin
                writes++;
                check($sformatf("vec%0d_b_count", i), b_hs_total, writes);
            end
        end
        aw_delay = 0; w_delay = 0; ar_delay = 0;

        // Minimum latency against a zero-wait slave.
        send_cmd(1'b1, 32'h18, 32'h11112222, 4'hF, '{32'h0, 2'b00, 1'b0}, t0);
        @(negedge CLK);
        check("lat_t1_aw_w_ar", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 3'b110);
        @(negedge CLK);
        check("lat_t2_aw_w_bready_rsp", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, rsp_valid}, 4'b0010);
        @(negedge CLK);
        check("lat_t3_rsp_valid", rsp_valid, 1'b1);
        @(posedge CLK); #1;
        wait_rsp("latency");
        writes++;
        check("lat_b_count", b_hs_total, writes);

        // Read timeout: slave never raises ARREADY.
        ar_block = 1'b1;
        send_cmd(1'b0, 32'h04, 32'h0, 4'h0, '{32'h0, 2'b11, 1'b1}, t0);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (rsp_valid) break;
            if (M_AXI_ARVALID) n++;
        end
        check("tmo_arvalid_cycles", n, TMO);
        check("tmo_rsp_latency", cyc - t0, TMO + 1);
        check("tmo_arvalid_rready_low", {M_AXI_ARVALID, M_AXI_RREADY}, 2'b00);
        @(posedge CLK); #1;
        ar_block = 1'b0;
        wait_rsp("timeout");

        // Host stalls the response for 10 cycles.
        rsp_ready = 1'b0;
        send_cmd(1'b0, 32'h04, 32'h0, 4'h0, '{32'hDEADBEEF, 2'b00, 1'b0}, t0);
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge CLK); n++; end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (!rsp_valid || rsp_rdata !== 32'hDEADBEEF || rsp_resp !== 2'b00 ||
                rsp_timeout || cmd_ready) bad++;
            @(negedge CLK);
        end
        check("stall_hold_deviations", bad, 0);
        @(posedge CLK); #1;
        rsp_ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("stall_release_cmd_ready_rsp_valid", {cmd_ready, rsp_valid}, 2'b10);
        @(posedge CLK); #1;
        wait_rsp("stall");

        // Reset while waiting for B.
        b_hold = 1'b1;
        send_cmd(1'b1, 32'h1C, 32'h77777777, 4'hF, '{32'h0, 2'b00, 1'b0}, t0);
        n = 0;
        while (!M_AXI_BREADY && n < 50) begin @(negedge CLK); n++; end
        check("rst_mid_reached_wr_resp", M_AXI_BREADY, 1'b1);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        check_reset("rst_mid");
        @(posedge CLK); #1;
        RST = 1'b0;
        sb_q.delete();
        b_hold = 1'b0;
        @(posedge CLK); #1;

        // Recovery after reset.
        send_cmd(1'b0, 32'h04, 32'h0, 4'h0, '{32'hDEADBEEF, 2'b00, 1'b0}, t0);
        wait_rsp("post_reset_read");
        send_cmd(1'b0, 32'h18, 32'h0, 4'h0, '{32'h11112222, 2'b00, 1'b0}, t0);
        wait_rsp("post_reset_read2");

        repeat (3) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
